// File: rtl/semaforo_pkg.sv
// Shared types and default phase durations for the traffic-light controller.
// PISCA exists only when SEMAFORO_NOTURNO_EN is defined.
package semaforo_pkg;

  typedef logic [4:0] tempo_t;

  typedef enum logic [2:0] {
    ST_VERMELHO,
    ST_VERDE,
    ST_AMARELO,
`ifdef SEMAFORO_NOTURNO_EN
    ST_PISCA,
`endif
    ST_FALHA
  } estado_t;

  localparam int T_VERDE_DEF        = 20;
  localparam int T_AMARELO_DEF      = 4;
  localparam int T_VERMELHO_DEF     = 15;
  localparam int T_VERMELHO_PED_DEF = 25;
  localparam int T_PISCA_DEF        = 7;

  localparam int T_MIN = 1;
  localparam int T_MAX = 29;

  function automatic bit tempo_valido(input int t);
    return (t >= T_MIN) && (t <= T_MAX);
  endfunction

endpackage

// File: rtl/semaforo_watchdog.sv
// Phase watchdog: cnt_fase tracks cycles since the last phase change, flags an
// early or late fim, and doubles as the flash divider once the controller is in fault.
module semaforo_watchdog
  import semaforo_pkg::*;
#(
  parameter tempo_t T_PISCA = tempo_t'(T_PISCA_DEF)
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   fim,
  input  tempo_t valor_maximo,
  input  logic   em_falha,
  output logic   erro,
  output logic   tick_pisca
);

  logic [5:0] cnt_fase;
  logic [5:0] limite;
  logic [5:0] limite_tarde;
  logic       precoce;
  logic       tardio;

  assign limite       = {1'b0, valor_maximo};
  assign limite_tarde = limite + 6'd2;

  // A fim one cycle after the expected slot is tolerated; two cycles without it is a fault.
  assign precoce    = fim && (cnt_fase < limite);
  assign tardio     = !fim && (cnt_fase == limite_tarde);
  assign erro       = !em_falha && (precoce || tardio);
  assign tick_pisca = em_falha && (cnt_fase == {1'b0, T_PISCA});

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_fase <= '0;
    end else if (em_falha) begin
      cnt_fase <= tick_pisca ? 6'd0 : cnt_fase + 6'd1;
    end else if (fim || erro) begin
      cnt_fase <= '0;
    end else begin
      cnt_fase <= cnt_fase + 6'd1;
    end
  end

endmodule

// File: rtl/semaforo_controlador.sv
// Traffic-light phase controller driving contador's valor_maximo from its fim pulse.
// Night flashing mode (noturno port, PISCA state) is built only with SEMAFORO_NOTURNO_EN.
//
//   state       | meaning
//   VERMELHO    | vehicle red, pedestrian walk when travessia=1
//   VERDE       | vehicle green
//   AMARELO     | vehicle amber
//   PISCA       | night mode, amber toggles on each fim
//   FALHA       | watchdog fault, amber flashes, left only by reset
module semaforo_controlador
  import semaforo_pkg::*;
#(
  parameter int T_VERDE        = T_VERDE_DEF,
  parameter int T_AMARELO      = T_AMARELO_DEF,
  parameter int T_VERMELHO     = T_VERMELHO_DEF,
  parameter int T_VERMELHO_PED = T_VERMELHO_PED_DEF,
  parameter int T_PISCA        = T_PISCA_DEF
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   fim,
  input  logic   botao,
`ifdef SEMAFORO_NOTURNO_EN
  input  logic   noturno,
`endif
  output tempo_t valor_maximo,
  output logic   verde,
  output logic   amarelo,
  output logic   vermelho,
  output logic   ped_verde,
  output logic   ped_vermelho,
  output logic   falha
);

  if (!tempo_valido(T_VERDE) || !tempo_valido(T_AMARELO) || !tempo_valido(T_VERMELHO) ||
      !tempo_valido(T_VERMELHO_PED) || !tempo_valido(T_PISCA)) begin : g_tempo_invalido
    $error("semaforo_controlador: every T_* must lie in 1..29");
  end

  localparam tempo_t TV  = tempo_t'(T_VERDE);
  localparam tempo_t TA  = tempo_t'(T_AMARELO);
  localparam tempo_t TVM = tempo_t'(T_VERMELHO);
  localparam tempo_t TVP = tempo_t'(T_VERMELHO_PED);
  localparam tempo_t TP  = tempo_t'(T_PISCA);

  estado_t estado, estado_prox;
  tempo_t  vm_prox;
  logic    verde_prox, amarelo_prox, vermelho_prox;
  logic    ped_verde_prox, ped_vermelho_prox, falha_prox;
  logic    pedido, pedido_prox;
  logic    travessia, travessia_prox;
  logic    wd_erro, wd_tick;

  semaforo_watchdog #(
    .T_PISCA (TP)
  ) u_watchdog (
    .clk          (clk),
    .reset        (reset),
    .fim          (fim),
    .valor_maximo (valor_maximo),
    .em_falha     (estado == ST_FALHA),
    .erro         (wd_erro),
    .tick_pisca   (wd_tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      estado       <= ST_VERMELHO;
      valor_maximo <= TVM;
      verde        <= 1'b0;
      amarelo      <= 1'b0;
      vermelho     <= 1'b1;
      ped_verde    <= 1'b0;
      ped_vermelho <= 1'b1;
      falha        <= 1'b0;
      pedido       <= 1'b0;
      travessia    <= 1'b0;
    end else begin
      estado       <= estado_prox;
      valor_maximo <= vm_prox;
      verde        <= verde_prox;
      amarelo      <= amarelo_prox;
      vermelho     <= vermelho_prox;
      ped_verde    <= ped_verde_prox;
      ped_vermelho <= ped_vermelho_prox;
      falha        <= falha_prox;
      pedido       <= pedido_prox;
      travessia    <= travessia_prox;
    end
  end

  always_comb begin
    estado_prox       = estado;
    vm_prox           = valor_maximo;
    verde_prox        = verde;
    amarelo_prox      = amarelo;
    vermelho_prox     = vermelho;
    ped_verde_prox    = ped_verde;
    ped_vermelho_prox = ped_vermelho;
    falha_prox        = falha;
    pedido_prox       = pedido;
    travessia_prox    = travessia;

    // The watchdog outranks every phase decision, including noturno and botao.
    if (wd_erro) begin
      estado_prox       = ST_FALHA;
      falha_prox        = 1'b1;
      verde_prox        = 1'b0;
      amarelo_prox      = 1'b1;
      vermelho_prox     = 1'b0;
      ped_verde_prox    = 1'b0;
      ped_vermelho_prox = 1'b0;
      travessia_prox    = 1'b0;
    end else begin
      case (estado)
        ST_VERMELHO: begin
          if (botao && !travessia) pedido_prox = 1'b1;
`ifdef SEMAFORO_NOTURNO_EN
          if (fim && noturno) begin
            estado_prox       = ST_PISCA;
            vm_prox           = TP;
            amarelo_prox      = 1'b1;
            vermelho_prox     = 1'b0;
            ped_verde_prox    = 1'b0;
            ped_vermelho_prox = 1'b0;
            travessia_prox    = 1'b0;
          end else
`endif
          if (fim) begin
            estado_prox       = ST_VERDE;
            vm_prox           = TV;
            verde_prox        = 1'b1;
            vermelho_prox     = 1'b0;
            ped_verde_prox    = 1'b0;
            ped_vermelho_prox = 1'b1;
            travessia_prox    = 1'b0;
          end
        end

        ST_VERDE: begin
          if (botao) pedido_prox = 1'b1;
          if (fim) begin
            estado_prox  = ST_AMARELO;
            vm_prox      = TA;
            verde_prox   = 1'b0;
            amarelo_prox = 1'b1;
          end
        end

        ST_AMARELO: begin
          if (fim) begin
            estado_prox   = ST_VERMELHO;
            amarelo_prox  = 1'b0;
            vermelho_prox = 1'b1;
            // A press landing on this very edge still earns the walk.
            if (pedido || botao) begin
              vm_prox           = TVP;
              ped_verde_prox    = 1'b1;
              ped_vermelho_prox = 1'b0;
              travessia_prox    = 1'b1;
              pedido_prox       = 1'b0;
            end else begin
              vm_prox           = TVM;
              ped_verde_prox    = 1'b0;
              ped_vermelho_prox = 1'b1;
              travessia_prox    = 1'b0;
            end
          end else if (botao) begin
            pedido_prox = 1'b1;
          end
        end

`ifdef SEMAFORO_NOTURNO_EN
        ST_PISCA: begin
          if (fim) begin
            if (noturno) begin
              amarelo_prox = !amarelo;
            end else begin
              estado_prox       = ST_VERMELHO;
              vm_prox           = TVM;
              amarelo_prox      = 1'b0;
              vermelho_prox     = 1'b1;
              ped_verde_prox    = 1'b0;
              ped_vermelho_prox = 1'b1;
              travessia_prox    = 1'b0;
            end
          end
        end
`endif

        ST_FALHA: begin
          if (wd_tick) amarelo_prox = !amarelo;
        end

        default: begin
          estado_prox       = ST_FALHA;
          falha_prox        = 1'b1;
          verde_prox        = 1'b0;
          amarelo_prox      = 1'b1;
          vermelho_prox     = 1'b0;
          ped_verde_prox    = 1'b0;
          ped_vermelho_prox = 1'b0;
          travessia_prox    = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_semaforo_controlador.sv
// Directed bench for semaforo_controlador with a stand-in contador; expected phases
// are queued ahead of each step and popped as the DUT completes each phase.
module tb_semaforo_controlador;
  import semaforo_pkg::*;

  logic   clk = 1'b0;
  logic   reset = 1'b1;
  logic   fim;
  logic   botao = 1'b0;
`ifdef SEMAFORO_NOTURNO_EN
  logic   noturno = 1'b0;
`endif
  tempo_t valor_maximo;
  logic   verde, amarelo, vermelho, ped_verde, ped_vermelho, falha;

  semaforo_controlador dut (
    .clk          (clk),
    .reset        (reset),
    .fim          (fim),
    .botao        (botao),
`ifdef SEMAFORO_NOTURNO_EN
    .noturno      (noturno),
`endif
    .valor_maximo (valor_maximo),
    .verde        (verde),
    .amarelo      (amarelo),
    .vermelho     (vermelho),
    .ped_verde    (ped_verde),
    .ped_vermelho (ped_vermelho),
    .falha        (falha)
  );

  always #5 clk = ~clk;

  // Compliant contador stand-in; sup_fim/inj_fim distort its fim for fault tests.
  logic [4:0] contagem;
  logic       fim_nat;
  logic       sup_fim = 1'b0;
  logic       inj_fim = 1'b0;

  always_ff @(posedge clk) begin
    if (reset) contagem <= 5'd0;
    else if (contagem >= valor_maximo) contagem <= 5'd0;
    else contagem <= contagem + 5'd1;
  end

  assign fim_nat = (contagem == valor_maximo);
  assign fim     = (fim_nat && !sup_fim) || inj_fim;

  // luzes = {falha, verde, amarelo, vermelho, ped_verde, ped_vermelho}
  localparam logic [5:0] L_VERMELHO = 6'b000101;
  localparam logic [5:0] L_VERM_PED = 6'b000110;
  localparam logic [5:0] L_VERDE    = 6'b010001;
  localparam logic [5:0] L_AMARELO  = 6'b001001;
  localparam logic [5:0] L_FALHA_ON = 6'b101000;
  localparam logic [5:0] L_FALHA_OF = 6'b100000;
`ifdef SEMAFORO_NOTURNO_EN
  localparam logic [5:0] L_PISCA_ON = 6'b001000;
  localparam logic [5:0] L_PISCA_OF = 6'b000000;
`endif

  typedef struct {
    string      tag;
    logic [5:0] luzes;
    logic [4:0] vm;
    bit         chk_vm;
    int         dur;
  } fase_t;

  fase_t fila[$];
  int n_comp   = 0;
  int n_falhas = 0;

  function automatic logic [5:0] luzes_now();
    return {falha, verde, amarelo, vermelho, ped_verde, ped_vermelho};
  endfunction

  task automatic checar(input string tag, input logic [31:0] obs, input logic [31:0] esp);
    n_comp++;
    assert (obs === esp) else begin
      n_falhas++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, esp);
    end
  endtask

  task automatic esperar(input string tag, input logic [5:0] luzes, input logic [4:0] vm,
                         input bit chk_vm, input int dur);
    fase_t e;
    e.tag = tag; e.luzes = luzes; e.vm = vm; e.chk_vm = chk_vm; e.dur = dur;
    fila.push_back(e);
  endtask

  // Measures the phase in progress (called at its first negedge) and checks it against
  // the next queued expectation. Stimulus indices count samples from 1 (cnt_fase = n-1).
  task automatic conferir(input int pulso_em, input bit pulso_no_fim, input bit suprimir,
                          input int injetar_em);
    fase_t      e;
    logic [5:0] l0;
    logic [4:0] v0;
    int         n;
    n_comp++;
    assert (fila.size() > 0) else begin
      n_falhas++;
      $error("FAIL fila: observed %0d queued expected >0", fila.size());
      return;
    end
    e  = fila.pop_front();
    l0 = luzes_now();
    v0 = valor_maximo;
    n  = 1;
    while (n < 100) begin
      sup_fim = suprimir;
      inj_fim = (n == injetar_em);
      botao   = (n == pulso_em) || (pulso_no_fim && fim_nat);
      @(negedge clk);
      if (luzes_now() !== l0 || valor_maximo !== v0) break;
      n++;
    end
    botao   = 1'b0;
    sup_fim = 1'b0;
    inj_fim = 1'b0;
    checar({e.tag, ".luzes"}, 32'(l0), 32'(e.luzes));
    if (e.chk_vm) checar({e.tag, ".valor_maximo"}, 32'(v0), 32'(e.vm));
    checar({e.tag, ".ciclos"}, n, e.dur);
  endtask

  task automatic aplicar_reset(input string tag);
    reset   = 1'b1;
    botao   = 1'b0;
    sup_fim = 1'b0;
    inj_fim = 1'b0;
    repeat (3) @(negedge clk);
    checar({tag, ".luzes"}, 32'(luzes_now()), 32'(L_VERMELHO));
    checar({tag, ".valor_maximo"}, 32'(valor_maximo), 32'd15);
    reset = 1'b0;
  endtask

  initial begin
    aplicar_reset("reset_inicial");

    // Plain cycle, no requests
    esperar("base_vermelho", L_VERMELHO, 5'd15, 1'b1, 16);
    esperar("base_verde",    L_VERDE,    5'd20, 1'b1, 21);
    esperar("base_amarelo",  L_AMARELO,  5'd4,  1'b1, 5);
    esperar("base_vermelho2", L_VERMELHO, 5'd15, 1'b1, 16);
    repeat (4) conferir(0, 1'b0, 1'b0, 0);

    // One-cycle press in green earns the next walk, then the request is gone
    esperar("ped_verde",     L_VERDE,    5'd20, 1'b1, 21);
    esperar("ped_amarelo",   L_AMARELO,  5'd4,  1'b1, 5);
    esperar("ped_travessia", L_VERM_PED, 5'd25, 1'b1, 26);
    esperar("ped_verde2",    L_VERDE,    5'd20, 1'b1, 21);
    esperar("ped_amarelo2",  L_AMARELO,  5'd4,  1'b1, 5);
    esperar("ped_sem_trav",  L_VERMELHO, 5'd15, 1'b1, 16);
    conferir(2, 1'b0, 1'b0, 0);
    repeat (5) conferir(0, 1'b0, 1'b0, 0);

    // Press only on the amber fim edge; press during walk is not latched
    esperar("borda_verde",    L_VERDE,    5'd20, 1'b1, 21);
    esperar("borda_amarelo",  L_AMARELO,  5'd4,  1'b1, 5);
    esperar("borda_trav",     L_VERM_PED, 5'd25, 1'b1, 26);
    esperar("borda_verde2",   L_VERDE,    5'd20, 1'b1, 21);
    esperar("borda_amarelo2", L_AMARELO,  5'd4,  1'b1, 5);
    esperar("borda_vermelho", L_VERMELHO, 5'd15, 1'b1, 16);
    conferir(0, 1'b0, 1'b0, 0);
    conferir(0, 1'b1, 1'b0, 0);
    conferir(5, 1'b0, 1'b0, 0);
    repeat (3) conferir(0, 1'b0, 1'b0, 0);

    // Missing fim at end of green: fault two cycles late, amber flashes with period 16
    esperar("tarde_verde",   L_VERDE,    5'd20, 1'b1, 23);
    esperar("tarde_pisca1",  L_FALHA_ON, 5'd0,  1'b0, 8);
    esperar("tarde_pisca0",  L_FALHA_OF, 5'd0,  1'b0, 8);
    esperar("tarde_pisca1b", L_FALHA_ON, 5'd0,  1'b0, 8);
    conferir(0, 1'b0, 1'b1, 0);
    repeat (3) conferir(0, 1'b0, 1'b0, 0);
    checar("tarde_falha_mantida", 32'(falha), 32'd1);
    aplicar_reset("reset_apos_tarde");

    // Early fim at cnt_fase=3 in green
    esperar("cedo_vermelho", L_VERMELHO, 5'd15, 1'b1, 16);
    esperar("cedo_verde",    L_VERDE,    5'd20, 1'b1, 4);
    esperar("cedo_pisca1",   L_FALHA_ON, 5'd0,  1'b0, 8);
    conferir(0, 1'b0, 1'b0, 0);
    conferir(0, 1'b0, 1'b0, 4);
    conferir(0, 1'b0, 1'b0, 0);
    aplicar_reset("reset_apos_cedo");

`ifdef SEMAFORO_NOTURNO_EN
    noturno = 1'b1;
    esperar("noite_vermelho",  L_VERMELHO, 5'd15, 1'b1, 16);
    esperar("noite_pisca1",    L_PISCA_ON, 5'd7,  1'b1, 8);
    esperar("noite_pisca0",    L_PISCA_OF, 5'd7,  1'b1, 8);
    esperar("noite_vermelho2", L_VERMELHO, 5'd15, 1'b1, 16);
    conferir(0, 1'b0, 1'b0, 0);
    conferir(0, 1'b0, 1'b0, 0);
    noturno = 1'b0;
    conferir(0, 1'b0, 1'b0, 0);
    conferir(0, 1'b0, 1'b0, 0);
`endif

    checar("fila_restante", fila.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_comp, n_falhas);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish before 200000");
    $fatal(1, "simulation time limit");
  end

endmodule
